// File: rtl/tdc_stamp.sv
// tdc_stamp: time-to-digital stamping front end.
//   A coarse cycle counter runs while armed. Each accepted hit rising edge
//   pushes {0, coarse, fine_in} into an output FIFO. A coarse wrap pushes a
//   marker word {1, 0.., 5'b0}. Words that find the FIFO full are dropped and
//   counted in a saturating drop counter.
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   enable     - 1 = count and accept hits, 0 = idle
//   hit        - hit level, already synchronous to clk
//   fine_in    - fine code, valid in the cycle a hit rising edge is seen
//   out_data   - {marker, coarse[COARSE_W-1:0], fine[4:0]}
//   out_valid  - out_data holds a word
//   out_ready  - consumer accepts the word on out_valid & out_ready
//   drop_cnt   - saturating count of words lost to a full FIFO
//   busy       - state not IDLE or FIFO non-empty
// Build option:
//   TDC_DEADTIME_EN - when defined, an accepted hit enters DEAD for DEAD_CYC
//                     cycles during which rises are ignored.
module tdc_stamp #(
  parameter int unsigned COARSE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DEAD_CYC   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  hit,
  input  logic [4:0]            fine_in,
  output logic [COARSE_W+5:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            drop_cnt,
  output logic                  busy
);

  localparam int unsigned W  = COARSE_W + 6;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("tdc_stamp: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (DEAD_CYC < 1) begin : g_bad_dead
    $error("tdc_stamp: DEAD_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ARMED
`ifdef TDC_DEADTIME_EN
    , DEAD
`endif
  } state_t;

  state_t                state, state_n;
  logic                  hit_q;
  logic                  pending;
  logic [COARSE_W-1:0]   coarse;
  logic                  running;
  logic                  rise;
  logic                  accept;
  logic                  wrap;
  logic                  push;
  logic [W-1:0]          push_word;
  logic [W-1:0]          marker_word;

  logic [W-1:0]          mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  empty, full, pop, do_push, drop;

`ifdef TDC_DEADTIME_EN
  localparam int unsigned DW = $clog2(DEAD_CYC + 1);
  logic [DW-1:0]         dcnt;
`endif

  assign running     = (state != IDLE);
  assign rise        = hit & ~hit_q;
  assign accept      = rise & (state == ARMED);
  assign wrap        = running & (coarse == '1);
  assign marker_word = {1'b1, {(W-1){1'b0}}};

  // A hit and a wrap in the same cycle: the hit word goes first and the
  // marker waits one cycle in the pending flag.
  assign push      = accept | pending | wrap;
  assign push_word = accept ? {1'b0, coarse, fine_in} : marker_word;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (enable) state_n = ARMED;
      ARMED: begin
        if (!enable) state_n = IDLE;
`ifdef TDC_DEADTIME_EN
        else if (accept) state_n = DEAD;
`endif
      end
`ifdef TDC_DEADTIME_EN
      DEAD: begin
        if (!enable) state_n = IDLE;
        else if (dcnt == DW'(DEAD_CYC - 1)) state_n = ARMED;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hit_q   <= 1'b0;
      pending <= 1'b0;
      coarse  <= '0;
    end else begin
      state   <= state_n;
      hit_q   <= hit;
      pending <= enable & accept & (wrap | pending);
      if (!enable || !running) coarse <= '0;
      else                     coarse <= coarse + COARSE_W'(1);
    end
  end

`ifdef TDC_DEADTIME_EN
  always_ff @(posedge clk) begin
    if (rst || state != DEAD) dcnt <= '0;
    else                      dcnt <= dcnt + DW'(1);
  end
`endif

  // FIFO with an extra pointer bit to tell full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = out_valid & out_ready;
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign busy      = running | ~empty;

endmodule
